pipe_alu: RTL

PIPE_ALU -- requirements
Module: pipe_alu

---
 rtl/pipe_alu.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_alu.sv
// pipe_alu: single-issue ALU with a registered result/flags stage and valid/ready handshakes.
// Define PIPE_ALU_MUL_EN to add the iterative shift-add multiplier for uop 10 (MUL).
module pipe_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       uop,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alu,
  output logic             out_wr,
  output logic [3:0]       flags_out,
  output logic             illegal
);

  localparam int unsigned W = WIDTH;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_XOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_ADC = 5'd9;
`ifdef PIPE_ALU_MUL_EN
  localparam logic [4:0] UOP_MUL = 5'd10;
`endif

  logic         w_idle;
  logic         w_accept;
  logic         w_cin;
  logic [W:0]   w_add;
  logic [W:0]   w_sub;
  logic [W:0]   w_lsl;
  logic [SHW:0] w_amt;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic         w_upd;
  logic         w_wr;
  logic         w_ill;
  logic         w_mul;

  logic         w_load;
  logic [W-1:0] w_ld_res;
  logic [3:0]   w_ld_flags;
  logic         w_ld_upd;
  logic         w_ld_wr;
  logic         w_ld_ill;

  logic         r_valid;
  logic [W-1:0] r_alu;
  logic         r_wr;
  logic         r_ill;
  logic [3:0]   r_flags;

  assign in_ready  = w_idle && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_valid;
  assign out_alu   = r_alu;
  assign out_wr    = r_wr;
  assign illegal   = r_ill;
  assign flags_out = r_flags;

  // Carry-in for ADC comes from the flags as they stand when the op is accepted.
  assign w_cin = (uop == UOP_ADC) && r_flags[1];
  assign w_add = {1'b0, lhs} + {1'b0, rhs} + (W+1)'(w_cin);
  assign w_sub = {1'b0, lhs} - {1'b0, rhs};
  assign w_amt = rhs[SHW:0];
  // Bit W of the widened shift is the last bit shifted out; amounts >= W leave zero.
  assign w_lsl = {1'b0, lhs} << w_amt;

  // Single-cycle datapath and op decode.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_upd = 1'b1;
    w_wr  = 1'b1;
    w_ill = 1'b0;
    w_mul = 1'b0;
    case (uop)
      UOP_NOP: begin
        w_upd = 1'b0;
        w_wr  = 1'b0;
      end
      UOP_ADD, UOP_ADC: begin
        w_res = w_add[W-1:0];
        w_c   = w_add[W];
        w_v   = (lhs[W-1] == rhs[W-1]) && (w_add[W-1] != lhs[W-1]);
      end
      UOP_SUB, UOP_CMP: begin
        w_res = w_sub[W-1:0];
        w_c   = w_sub[W];
        w_v   = (lhs[W-1] != rhs[W-1]) && (w_sub[W-1] != lhs[W-1]);
        w_wr  = (uop == UOP_SUB);
      end
      UOP_AND: w_res = lhs & rhs;
      UOP_XOR: w_res = lhs ^ rhs;
      UOP_MOV: w_res = rhs;
      UOP_LSR: w_res = lhs >> w_amt;
      UOP_LSL: begin
        w_res = w_lsl[W-1:0];
        w_c   = w_lsl[W];
      end
`ifdef PIPE_ALU_MUL_EN
      UOP_MUL: w_mul = 1'b1;
`endif
      default: begin
        w_upd = 1'b0;
        w_wr  = 1'b0;
        w_ill = 1'b1;
      end
    endcase
  end

`ifdef PIPE_ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_t;

  state_t         r_state;
  logic [SHW-1:0] r_cnt;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_mcand;
  logic [W:0]     w_psum;
  logic [2*W-1:0] w_prod_nxt;
  logic           w_mul_done;

  // Product register starts with the multiplier in the low half; add-and-shift-right per cycle.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_psum     = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_psum, r_prod[W-1:1]};
  assign w_mul_done = (r_state == ST_MUL_BUSY) && (r_cnt == SHW'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_mcand <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_mul) begin
            r_state <= ST_MUL_BUSY;
            r_cnt   <= '0;
            r_prod  <= {{W{1'b0}}, rhs};
            r_mcand <= lhs;
          end
        end
        ST_MUL_BUSY: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (w_mul_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign w_idle = 1'b1;
`endif

  // Result-register load source: finished multiply or a single-cycle op at accept.
  always_comb begin
    w_load     = w_accept && !w_mul;
    w_ld_res   = w_res;
    w_ld_flags = {w_v, w_res[W-1], w_c, ~|w_res};
    w_ld_upd   = w_upd;
    w_ld_wr    = w_wr;
    w_ld_ill   = w_ill;
`ifdef PIPE_ALU_MUL_EN
    if (w_mul_done) begin
      w_load     = 1'b1;
      w_ld_res   = w_prod_nxt[W-1:0];
      w_ld_flags = {1'b0, w_prod_nxt[W-1], |w_prod_nxt[2*W-1:W], ~|w_prod_nxt[W-1:0]};
      w_ld_upd   = 1'b1;
      w_ld_wr    = 1'b1;
      w_ld_ill   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_wr    <= 1'b0;
      r_ill   <= 1'b0;
      r_flags <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_alu   <= w_ld_res;
      r_wr    <= w_ld_wr;
      r_ill   <= w_ld_ill;
      if (w_ld_upd) r_flags <= w_ld_flags;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
